// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect from execute,
// and the instruction handshake toward decode. Master is the fetch unit.
interface instr_fetch_unit_if;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  modport master (
    output imem_req_valid_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC sequencing, credit-limited imem requests, in-order response
// capture into a small registered buffer, and redirect with in-flight response dropping.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instr_fetch_unit_if.master bus
);

  localparam int          CW  = $clog2(DEPTH + 1);
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [31:0]   buf_pc_q    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];

  logic [CW+1:0] used;
  logic          req_fire, rsp_drop, rsp_live, pop, wr_en, head_vld;
  logic [31:0]   target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Buffered, live in-flight and to-be-dropped requests all hold one credit each.
  assign used     = {2'b00, cnt_q} + {2'b00, out_q} + {2'b00, drop_q};
  assign bus.imem_req_valid_o = !rst_i && !bus.redirect_i && (used < (CW+2)'(DEPTH));
  assign bus.imem_addr_o      = fetch_pc_q;

  assign req_fire = bus.imem_req_valid_o && bus.imem_req_ready_i;
  assign rsp_drop = bus.imem_rsp_valid_i && (drop_q != '0);
  assign rsp_live = bus.imem_rsp_valid_i && (drop_q == '0) && (out_q != '0);
  assign head_vld = (cnt_q != '0);
  assign pop      = head_vld && bus.instr_ready_i;
  assign target   = bus.redirect_pc_i & ~32'h3;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wr_en      = 1'b0;
    if (bus.redirect_i) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      out_d      = '0;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      // A response arriving now retires one of the requests being turned into drops.
      drop_d     = drop_q + out_q -
                   CW'(bus.imem_rsp_valid_i && ((drop_q != '0) || (out_q != '0)));
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) drop_d = drop_q - 1'b1;
      if (rsp_live) begin
        wr_en    = 1'b1;
        wr_d     = ptr_inc(wr_q);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_d = ptr_inc(rd_q);
      out_d = out_q + CW'(req_fire) - CW'(rsp_live);
      cnt_d = cnt_q + CW'(rsp_live) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Buffer payload is qualified by cnt_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      buf_pc_q[wr_q]    <= rsp_pc_q;
      buf_instr_q[wr_q] <= bus.imem_rsp_data_i;
    end
  end

  assign bus.instr_valid_o = head_vld;
  assign bus.instr_o       = head_vld ? buf_instr_q[rd_q] : NOP;
  assign bus.pc_o          = head_vld ? buf_pc_q[rd_q] : 32'h0;
  assign bus.pc_plus4_o    = head_vld ? buf_pc_q[rd_q] + 32'd4 : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference of in-flight requests and buffered
// instructions, random memory latency/ready, directed redirect, stall and reset scenarios.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC   = 32'hFFFF_FFFC;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          drop;
  } infl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ready_pct, dec_pct, lat_min, lat_max;
  infl_t       infl[$];
  ent_t        bq[$];
  logic [31:0] fpc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs_reset();
    check("rst_req_valid", {31'b0, ifc.imem_req_valid_o}, 32'd0);
    check("rst_instr_valid", {31'b0, ifc.instr_valid_o}, 32'd0);
    check("rst_instr", ifc.instr_o, NOP);
    check("rst_pc", ifc.pc_o, 32'h0);
    check("rst_pc_plus4", ifc.pc_plus4_o, 32'h0);
  endtask

  // Called on a falling edge; asserts reset immediately and releases it two edges later.
  task automatic apply_reset();
    rst = 1'b1;
    ifc.imem_req_ready_i = 1'b0;
    ifc.imem_rsp_valid_i = 1'b0;
    ifc.imem_rsp_data_i  = 32'h0;
    ifc.redirect_i       = 1'b0;
    ifc.redirect_pc_i    = 32'h0;
    ifc.instr_ready_i    = 1'b0;
    #1;
    check_outputs_reset();
    infl.delete();
    bq.delete();
    fpc = RPC;
    repeat (2) @(posedge clk);
    cyc += 2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit    rsp, rdy, drdy, exp_rv, fire;
    infl_t e;
    ent_t  n;
    int    d;
    rsp  = (infl.size() > 0) && (infl[0].due <= cyc);
    rdy  = ($urandom_range(99) < ready_pct);
    drdy = ($urandom_range(99) < dec_pct);
    ifc.imem_rsp_valid_i = rsp;
    ifc.imem_rsp_data_i  = rsp ? memf(infl[0].addr) : 32'hDEAD_BEEF;
    ifc.imem_req_ready_i = rdy;
    ifc.instr_ready_i    = drdy;
    ifc.redirect_i       = redir;
    ifc.redirect_pc_i    = rpc;
    #1;
    exp_rv = !redir && ((bq.size() + infl.size()) < DEPTH);
    check("req_valid", {31'b0, ifc.imem_req_valid_o}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", ifc.imem_addr_o, fpc);
    check("instr_valid", {31'b0, ifc.instr_valid_o}, {31'b0, bq.size() != 0});
    check("instr", ifc.instr_o, (bq.size() != 0) ? bq[0].instr : NOP);
    check("pc", ifc.pc_o, (bq.size() != 0) ? bq[0].pc : 32'h0);
    check("pc_plus4", ifc.pc_plus4_o, (bq.size() != 0) ? bq[0].pc + 32'd4 : 32'h0);

    fire = exp_rv && rdy;
    if (!redir && drdy && bq.size() != 0) void'(bq.pop_front());
    if (rsp) begin
      e = infl.pop_front();
      if (!e.drop && !redir) begin
        n.pc    = e.addr;
        n.instr = memf(e.addr);
        bq.push_back(n);
      end
    end
    if (redir) begin
      bq.delete();
      foreach (infl[i]) infl[i].drop = 1'b1;
      fpc = rpc & ~32'h3;
    end
    if (fire) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (infl.size() > 0 && infl[infl.size()-1].due >= d) d = infl[infl.size()-1].due + 1;
      e.addr = fpc;
      e.due  = d;
      e.drop = 1'b0;
      infl.push_back(e);
      fpc = fpc + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int k;
    ready_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
    @(negedge clk);
    apply_reset();

    // Streaming with single-cycle memory; the first request goes to the wrapping reset PC.
    check("first_addr", ifc.imem_addr_o, RPC);
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0);

    // Decode stall, then release.
    dec_pct = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
    dec_pct = 100;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);

    // Redirect to an unaligned target with two requests in flight.
    lat_min = 3; lat_max = 3;
    k = 0;
    while (!(infl.size() == 2 && bq.size() == 0 && !infl[0].drop && !infl[1].drop) && k < 60) begin
      step(1'b0, 32'h0);
      k++;
    end
    check("wait_two_inflight", k < 60, 1);
    step(1'b1, 32'h0000_0103);
    k = 0;
    while (!ifc.instr_valid_o && k < 40) begin
      step(1'b0, 32'h0);
      k++;
    end
    check("redir_first_pc", ifc.pc_o, 32'h0000_0100);
    check("redir_first_instr", ifc.instr_o, memf(32'h0000_0100));
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);

    // Redirect coinciding with a live response and a pop.
    lat_min = 1; lat_max = 1;
    k = 0;
    while (!(bq.size() > 0 && infl.size() > 0 && infl[0].due <= cyc && !infl[0].drop) && k < 40) begin
      step(1'b0, 32'h0);
      k++;
    end
    check("wait_rsp_pop", k < 40, 1);
    step(1'b1, 32'h0000_0200);
    check("redir_empty_next", {31'b0, ifc.instr_valid_o}, 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0);

    // Randomised traffic with occasional redirects.
    ready_pct = 70; dec_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) step($urandom_range(99) < 5, $urandom);

    // Fill the buffer, then reset mid-cycle.
    ready_pct = 100; dec_pct = 0; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    check("full_before_reset", {31'b0, ifc.instr_valid_o}, 32'd1);
    #2;
    apply_reset();
    check("restart_addr", ifc.imem_addr_o, RPC);
    dec_pct = 100;
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
